// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared types and constants for the RV immediate generator.
//               - imm_fmt_e : immediate format tag carried with each entry
//               - OPC_*     : base opcodes that carry an immediate
//               - F3_*      : OP-IMM funct3 codes that select the shift form
//               - fmt_of()  : opcode/funct3 -> immediate format
// Revision    : 1.0  initial release
// ============================================================================
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // OP-IMM funct3 values whose immediate field is a shift amount
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   // Classify an instruction by opcode (and funct3 for OP-IMM).
   // Unknown opcodes are not an error; they simply carry no immediate.
   function automatic imm_fmt_e fmt_of(input logic [6:0] opcode,
                                       input logic [2:0] funct3);
      imm_fmt_e f;
      f = FMT_NONE;
      case (opcode)
         OPC_LOAD,
         OPC_JALR:   f = FMT_I;
         OPC_OPIMM:  f = ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) ? FMT_SH : FMT_I;
         OPC_STORE:  f = FMT_S;
         OPC_BRANCH: f = FMT_B;
         OPC_LUI,
         OPC_AUIPC:  f = FMT_U;
         OPC_JAL:    f = FMT_J;
         default:    f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Purely combinational RV immediate decoder.
//               Builds the 32-bit immediate for every base format, then
//               sign-fills to XLEN. Shift amounts are zero-extended and are
//               6 bits wide on RV64, 5 bits on RV32.
// Ports       : inst  in  32    raw instruction word
//               imm   out XLEN  decoded immediate
//               fmt   out 3     imm_fmt_e code of the decoded format
// Parameters  : XLEN  32 or 64
// Revision    : 1.0  initial release
// ============================================================================
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt
);

   imm_fmt_e    w_fmt;
   logic [31:0] w_raw;     // immediate sign-extended to 32 bits
   logic [31:0] w_shamt;   // zero-extended shift amount

   assign w_fmt = fmt_of(inst[6:0], inst[14:12]);
   assign fmt   = w_fmt;

   // RV64 shifts use a 6-bit shamt; on RV32 inst[25] is part of funct7.
   generate
      if (XLEN == 64) begin : g_shamt_64
         assign w_shamt = {26'b0, inst[25:20]};
      end else begin : g_shamt_32
         assign w_shamt = {27'b0, inst[24:20]};
      end
   endgenerate

   always_comb begin
      w_raw = 32'b0;
      case (w_fmt)
         FMT_I:   w_raw = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   w_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   w_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                           inst[11:8], 1'b0};
         FMT_U:   w_raw = {inst[31:12], 12'b0};
         FMT_J:   w_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                           inst[30:21], 1'b0};
         FMT_SH:  w_raw = w_shamt;
         default: w_raw = 32'b0;
      endcase
   end

   // Bit 31 of w_raw is already the correct fill for every format: the sign
   // for I/S/B/U/J, and zero for SH and NONE.
   generate
      if (XLEN == 64) begin : g_fill_64
         assign imm = {{32{w_raw[31]}}, w_raw};
      end else begin : g_fill_32
         assign imm = w_raw;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined RV immediate generator for the decode stage.
//               Decodes on the input side, then registers {imm, fmt, tag}
//               behind a valid/ready handshake with a 2-entry skid buffer
//               (main register M drives the outputs, skid register K absorbs
//               the one extra beat accepted while the output is stalled).
//               Flush synchronously kills both entries.
// Ports       : clk        in   1      clock, rising edge
//               rst_n      in   1      asynchronous active-low reset
//               flush      in   1      synchronous kill of buffered entries
//               in_valid   in   1      in_inst/in_tag valid
//               in_ready   out  1      block can accept this cycle
//               in_inst    in   32     raw instruction word
//               in_tag     in   TAG_W  sideband tag, passed through
//               out_valid  out  1      out_* valid
//               out_ready  in   1      consumer accepts this cycle
//               out_imm    out  XLEN   decoded immediate
//               out_fmt    out  3      imm_fmt_e code
//               out_tag    out  TAG_W  tag of the entry on out_imm
// Parameters  : XLEN   32 or 64
//               TAG_W  sideband tag width
// Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic [TAG_W-1:0] tag;
   } imm_entry_t;

   // ------------------------------------------------------------------------
   // Input-side decode: M and K store already-decoded entries.
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] w_dec_imm;
   logic [2:0]      w_dec_fmt;
   imm_entry_t      w_dec;

   imm_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .inst (in_inst),
      .imm  (w_dec_imm),
      .fmt  (w_dec_fmt)
   );

   assign w_dec.imm = w_dec_imm;
   assign w_dec.fmt = imm_fmt_e'(w_dec_fmt);
   assign w_dec.tag = in_tag;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic       r_m_v;
   logic       r_k_v;
   imm_entry_t r_m;
   imm_entry_t r_k;

   // ------------------------------------------------------------------------
   // Handshake and load control
   // ------------------------------------------------------------------------
   logic w_in_fire;
   logic w_out_fire;
   logic w_m_free;     // M is empty or being drained this cycle
   logic w_m_load_k;   // K advances into M
   logic w_m_load_in;  // new input goes straight into M
   logic w_k_load;     // new input parks in K behind a stalled M

   // in_ready depends only on registered state, so there is no
   // combinational path from out_ready back to the producer.
   assign in_ready   = ~r_k_v;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_m_v & out_ready;
   assign w_m_free   = w_out_fire | ~r_m_v;

   // in_ready is low whenever K holds an entry, so K->M and input->M are
   // mutually exclusive without further gating.
   assign w_m_load_k  = ~flush & w_m_free & r_k_v;
   assign w_m_load_in = ~flush & w_m_free & w_in_fire;
   assign w_k_load    = ~flush & ~w_m_free & w_in_fire;

   // Valid bits: flush wins over everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_v <= 1'b0;
         r_k_v <= 1'b0;
      end else if (flush) begin
         r_m_v <= 1'b0;
         r_k_v <= 1'b0;
      end else if (w_m_free) begin
         r_m_v <= r_k_v | w_in_fire;
         r_k_v <= 1'b0;
      end else if (w_in_fire) begin
         r_k_v <= 1'b1;
      end
   end

   // M payload is reset because it drives out_* directly and those must read
   // zero while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= '0;
      end else if (w_m_load_k) begin
         r_m <= r_k;
      end else if (w_m_load_in) begin
         r_m <= w_dec;
      end
   end

   // K payload is never observed unless r_k_v is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_k_load) begin
         r_k <= w_dec;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: always from M
   // ------------------------------------------------------------------------
   assign out_valid = r_m_v;
   assign out_imm   = r_m.imm;
   assign out_fmt   = r_m.fmt;
   assign out_tag   = r_m.tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64
//               instances). A queue model derived from the immediate
//               encoding rules tracks the 32-bit instance on every cycle;
//               directed vectors pin literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   localparam int TAG_W = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_imm;
   logic [2:0]       out_fmt;
   logic [TAG_W-1:0] out_tag;

   logic             in_valid64;
   logic             in_ready64;
   logic [31:0]      in_inst64;
   logic             out_valid64;
   logic [63:0]      out_imm64;
   logic [2:0]       out_fmt64;
   logic [TAG_W-1:0] out_tag64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_fmt   (out_fmt),
      .out_tag   (out_tag)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .in_valid  (in_valid64),
      .in_ready  (in_ready64),
      .in_inst   (in_inst64),
      .in_tag    (5'd0),
      .out_valid (out_valid64),
      .out_ready (1'b1),
      .out_imm   (out_imm64),
      .out_fmt   (out_fmt64),
      .out_tag   (out_tag64)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Immediate value from the encoding rules, using arithmetic on the
   // sign-extended instruction word.
   function automatic logic [63:0] model_imm(input logic [31:0] i, input int xlen,
                                             output logic [2:0] fmt);
      longint      s;
      logic [63:0] r;
      s   = longint'($signed(i));
      r   = 64'd0;
      fmt = 3'd0;
      case (i[6:0])
         7'h03, 7'h67: begin r = 64'(s >>> 20); fmt = 3'd1; end
         7'h13: begin
            if (i[14:12] == 3'b001 || i[14:12] == 3'b101) begin
               r   = (xlen == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
               fmt = 3'd6;
            end else begin
               r = 64'(s >>> 20); fmt = 3'd1;
            end
         end
         7'h23: begin
            r = 64'((s >>> 25) <<< 5) | 64'(i[11:7]); fmt = 3'd2;
         end
         7'h63: begin
            r = 64'((s >>> 31) <<< 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5)
              | (64'(i[11:8]) << 1);
            fmt = 3'd3;
         end
         7'h37, 7'h17: begin r = 64'(s) & ~64'hFFF; fmt = 3'd4; end
         7'h6F: begin
            r = 64'((s >>> 31) <<< 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11)
              | (64'(i[30:21]) << 1);
            fmt = 3'd5;
         end
         default: begin r = 64'd0; fmt = 3'd0; end
      endcase
      if (xlen == 32) r = r & 64'hFFFF_FFFF;
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Scoreboard for the 32-bit instance: checked at every falling edge.
   // ------------------------------------------------------------------------
   typedef struct {
      logic [63:0]      imm;
      logic [2:0]       fmt;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb[$];
   logic             prev_stall = 1'b0;
   logic [31:0]      prev_imm;
   logic [2:0]       prev_fmt;
   logic [TAG_W-1:0] prev_tag;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         chk("sb_out_valid", 64'(out_valid), 64'(sb.size() != 0));
         chk("sb_in_ready",  64'(in_ready),  64'(sb.size() < 2));
         if (out_valid && sb.size() != 0) begin
            chk("sb_imm", 64'(out_imm), sb[0].imm);
            chk("sb_fmt", 64'(out_fmt), 64'(sb[0].fmt));
            chk("sb_tag", 64'(out_tag), 64'(sb[0].tag));
         end
         if (out_valid && prev_stall) begin
            chk("stall_imm", 64'(out_imm), 64'(prev_imm));
            chk("stall_fmt", 64'(out_fmt), 64'(prev_fmt));
            chk("stall_tag", 64'(out_tag), 64'(prev_tag));
         end
         prev_stall = out_valid & ~out_ready;
         prev_imm   = out_imm;
         prev_fmt   = out_fmt;
         prev_tag   = out_tag;
         if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
            exp_t e;
            e.imm = model_imm(in_inst, 32, e.fmt);
            e.tag = in_tag;
            sb.push_back(e);
         end
      end
   end

   // Offer one instruction and return one cycle after it is accepted
   // (in_valid left asserted; the caller decides what comes next).
   task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_inst  = inst;
      in_tag   = tag;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: tag %0d not accepted, expected within 20 cycles", tag);
   endtask

   // Reference vectors: 0..6 for XLEN=32, 7..9 for XLEN=64.
   logic [31:0] t_inst [10];
   logic [63:0] t_imm  [10];
   logic [2:0]  t_fmt  [10];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  mf;
      logic [63:0] mi;

      t_inst[0] = 32'hFFC12083; t_imm[0] = 64'hFFFFFFFC;         t_fmt[0] = 3'd1;
      t_inst[1] = 32'hFE112E23; t_imm[1] = 64'hFFFFFFFC;         t_fmt[1] = 3'd2;
      t_inst[2] = 32'hFE000CE3; t_imm[2] = 64'hFFFFFFF8;         t_fmt[2] = 3'd3;
      t_inst[3] = 32'h0010006F; t_imm[3] = 64'h00000800;         t_fmt[3] = 3'd5;
      t_inst[4] = 32'h123452B7; t_imm[4] = 64'h12345000;         t_fmt[4] = 3'd4;
      t_inst[5] = 32'h01F09093; t_imm[5] = 64'h0000001F;         t_fmt[5] = 3'd6;
      t_inst[6] = 32'h00208033; t_imm[6] = 64'h00000000;         t_fmt[6] = 3'd0;
      t_inst[7] = 32'hFFC12083; t_imm[7] = 64'hFFFFFFFFFFFFFFFC; t_fmt[7] = 3'd1;
      t_inst[8] = 32'h800002B7; t_imm[8] = 64'hFFFFFFFF80000000; t_fmt[8] = 3'd4;
      t_inst[9] = 32'h03F09093; t_imm[9] = 64'h000000000000003F; t_fmt[9] = 3'd6;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0;
      out_ready = 1'b1; in_valid64 = 1'b0; in_inst64 = '0;

      // Reset state
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_imm",   64'(out_imm),   64'd0);
      chk("rst_out_fmt",   64'(out_fmt),   64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);

      // Pin the model to hand-computed values
      for (int i = 0; i < 10; i++) begin
         mi = model_imm(t_inst[i], (i < 7) ? 32 : 64, mf);
         chk($sformatf("model_imm[%0d]", i), mi, t_imm[i]);
         chk($sformatf("model_fmt[%0d]", i), 64'(mf), 64'(t_fmt[i]));
      end

      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Streaming at full rate: each result appears one edge after its fire
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_inst  = t_inst[i];
         in_tag   = TAG_W'(i + 1);
         @(posedge clk); #1;
         chk($sformatf("stream_valid[%0d]", i), 64'(out_valid), 64'd1);
         chk($sformatf("stream_imm[%0d]", i),   64'(out_imm),   t_imm[i]);
         chk($sformatf("stream_fmt[%0d]", i),   64'(out_fmt),   64'(t_fmt[i]));
         chk($sformatf("stream_tag[%0d]", i),   64'(out_tag),   64'(i + 1));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stream_drained", 64'(out_valid), 64'd0);

      // XLEN=64 instance
      for (int i = 7; i < 10; i++) begin
         in_valid64 = 1'b1;
         in_inst64  = t_inst[i];
         @(posedge clk); #1;
         chk($sformatf("x64_valid[%0d]", i), 64'(out_valid64), 64'd1);
         chk($sformatf("x64_imm[%0d]", i),   out_imm64,        t_imm[i]);
         chk($sformatf("x64_fmt[%0d]", i),   64'(out_fmt64),   64'(t_fmt[i]));
         chk($sformatf("x64_tag[%0d]", i),   64'(out_tag64),   64'd0);
         chk($sformatf("x64_ready[%0d]", i), 64'(in_ready64),  64'd1);
      end
      in_valid64 = 1'b0;
      @(posedge clk); #1;

      // Backpressure: tags 1,2 accepted, 3 held until the stall clears
      out_ready = 1'b0;
      send(t_inst[0], 5'd1);
      send(t_inst[1], 5'd2);
      in_inst = t_inst[2];
      in_tag  = 5'd3;
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         chk("bp_hold_ready", 64'(in_ready), 64'd0);
         chk("bp_hold_tag",   64'(out_tag),  64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_tag2",   64'(out_tag),   64'd2);
      chk("bp_ready2", 64'(in_ready),  64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_tag3",   64'(out_tag),   64'd3);
      chk("bp_valid3", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      chk("bp_empty",  64'(out_valid), 64'd0);

      // Flush with M and K full; tag 7 offered but never accepted
      out_ready = 1'b0;
      send(t_inst[3], 5'd5);
      send(t_inst[4], 5'd6);
      in_inst = t_inst[5];
      in_tag  = 5'd7;
      flush   = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready",  64'(in_ready),  64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Flush discards a same-cycle input fire
      out_ready = 1'b0;
      send(t_inst[0], 5'd8);
      in_inst = t_inst[1];
      in_tag  = 5'd9;
      flush   = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush2_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("flush2_still_empty", 64'(out_valid), 64'd0);

      // Asynchronous reset mid-stall
      out_ready = 1'b0;
      send(t_inst[2], 5'd10);
      send(t_inst[3], 5'd11);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_imm",   64'(out_imm),   64'd0);
      chk("arst_out_tag",   64'(out_tag),   64'd0);
      chk("arst_in_ready",  64'(in_ready),  64'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready",  64'(in_ready),  64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = t_inst[0];
      in_tag    = 5'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_tag",   64'(out_tag),   64'd12);
      chk("post_rst_imm",   64'(out_imm),   t_imm[0]);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
